// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, in-order grant/response imem requests and a
// tagged 2-entry return queue feeding decode; jumps discard in-flight responses.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    logic [31:0] r_pc;
    logic [31:0] r_addr [2];
    logic [31:0] r_data [2];
    logic [1:0]  r_alloc;
    logic [1:0]  r_filled;
    logic        r_wr_ptr;
    logic        r_fill_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_drop_cnt;
    logic        r_req_en;

    logic        w_head_valid;
    logic        w_pop;
    logic        w_grant;
    logic        w_fill;
    logic        w_drop;
    logic [1:0]  w_alloc_cnt;
    logic [1:0]  w_unfilled;
    logic [2:0]  w_credit;
    logic [2:0]  w_jump_drop;

    assign w_head_valid = r_alloc[r_rd_ptr] & r_filled[r_rd_ptr];
    assign inst_valid_o = w_head_valid & ~jump_en_i;
    assign w_pop        = inst_valid_o & ~hold_i;
    assign inst_o       = inst_valid_o ? r_data[r_rd_ptr] : NOP_INST;
    assign inst_addr_o  = inst_valid_o ? r_addr[r_rd_ptr] : 32'h0;

    assign w_alloc_cnt  = {1'b0, r_alloc[0]} + {1'b0, r_alloc[1]};
    assign w_unfilled   = {1'b0, r_alloc[0] & ~r_filled[0]} + {1'b0, r_alloc[1] & ~r_filled[1]};

    // A same-cycle pop frees a slot, so it counts as credit immediately.
    assign w_credit     = {1'b0, w_alloc_cnt} + {1'b0, r_drop_cnt} - {2'b00, w_pop};
    assign imem_req_o   = r_req_en & ~jump_en_i & (w_credit < 3'd2);
    assign imem_addr_o  = r_pc;
    assign w_grant      = imem_req_o & imem_gnt_i;

    assign w_fill       = imem_rvalid_i & (r_drop_cnt == 2'd0);
    assign w_drop       = imem_rvalid_i & (r_drop_cnt != 2'd0);
    assign w_jump_drop  = {1'b0, r_drop_cnt} + {1'b0, w_unfilled} - {2'b00, imem_rvalid_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_alloc    <= 2'b00;
            r_filled   <= 2'b00;
            r_wr_ptr   <= 1'b0;
            r_fill_ptr <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_drop_cnt <= 2'd0;
            r_req_en   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_addr[i] <= 32'h0;
                r_data[i] <= 32'h0;
            end
        end else begin
            r_req_en <= 1'b1;
            if (jump_en_i) begin
                r_pc       <= jump_addr_i;
                r_alloc    <= 2'b00;
                r_filled   <= 2'b00;
                r_wr_ptr   <= 1'b0;
                r_fill_ptr <= 1'b0;
                r_rd_ptr   <= 1'b0;
                r_drop_cnt <= w_jump_drop[1:0];
            end else begin
                if (w_fill) begin
                    r_data[r_fill_ptr]   <= imem_rdata_i;
                    r_filled[r_fill_ptr] <= 1'b1;
                    r_fill_ptr           <= ~r_fill_ptr;
                end else if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - 2'd1;
                end
                if (w_pop) begin
                    r_alloc[r_rd_ptr] <= 1'b0;
                    r_rd_ptr          <= ~r_rd_ptr;
                end
                // Placed after the pop so a full-queue pop+grant re-allocates the same slot.
                if (w_grant) begin
                    r_alloc[r_wr_ptr]  <= 1'b1;
                    r_filled[r_wr_ptr] <= 1'b0;
                    r_addr[r_wr_ptr]   <= r_pc;
                    r_pc               <= r_pc + 32'd4;
                    r_wr_ptr           <= ~r_wr_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a bench-side memory model answers grants,
// expected fetches are queued at grant time, a monitor checks decode output.
module tb_if_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        hold_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    if_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_i       (hold_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          first_cyc = -1;
    int          jump_cyc = 0;
    int          n_valid = 0;
    int          n_pop = 0;
    logic        gnt_allow = 1'b1;
    logic        hold_c = 1'b0;
    logic        jump_c = 1'b0;
    logic [31:0] jaddr_c = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_q [$];
    resp_t       pend [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: memory response, control inputs, then grant decision.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = pend[0].addr ^ KEY;
            void'(pend.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end
        hold_i      = hold_c;
        jump_en_i   = jump_c;
        jump_addr_i = jaddr_c;
        #1;
        if (jump_en_i) begin
            chk("req_in_jump", {31'b0, imem_req_o}, 32'd0);
            exp_q.delete();
            exp_pc   = jump_addr_i;
            jump_cyc = cyc;
        end
        if (imem_req_o && gnt_allow) begin
            imem_gnt_i = 1'b1;
            chk("fetch_addr", imem_addr_o, exp_pc);
            pend.push_back('{addr: exp_pc, due: cyc + lat});
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
            chk("outstanding_le2", {31'b0, pend.size() <= 2}, 32'd1);
        end else begin
            imem_gnt_i = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs();
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_imem_addr", imem_addr_o, 32'h0);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_inst_addr", inst_addr_o, 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        cyc       = 0;
        first_cyc = -1;
        n_valid   = 0;
        exp_pc    = 32'h0;
    endtask

    // Monitor: every presented instruction must match the scoreboard head.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (jump_en_i) chk("valid_in_jump", {31'b0, inst_valid_o}, 32'd0);
            if (inst_valid_o) begin
                n_valid++;
                if (first_cyc < 0) first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {31'b0, inst_valid_o}, 32'd0);
                end else begin
                    chk("inst_addr", inst_addr_o, exp_q[0]);
                    chk("inst_data", inst_o, exp_q[0] ^ KEY);
                    if (!hold_i) begin
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                end
            end else if (!jump_en_i) begin
                chk("idle_nop", inst_o, NOP);
                chk("idle_addr", inst_addr_o, 32'h0);
            end
        end
    end

    initial begin
        int p0;
        repeat (3) @(negedge clk);
        check_reset_outputs();

        // Zero-wait stream after reset release.
        release_reset();
        step();
        chk("req_cycle1", {31'b0, imem_req_o}, 32'd1);
        run(19);
        #3;
        chk("first_valid_cycle", first_cyc, 32'd3);
        chk("valid_every_cycle", n_valid, 32'd18);

        // Hold mid-stream for 5 cycles.
        hold_c = 1'b1;
        run(5);
        chk("req_drop_on_hold", {31'b0, imem_req_o}, 32'd0);
        hold_c = 1'b0;
        run(10);

        // 3-cycle memory, grant withheld for 2 cycles.
        lat = 3;
        run(10);
        gnt_allow = 1'b0;
        step();
        chk("pc_hold_1", imem_addr_o, exp_pc);
        step();
        chk("pc_hold_2", imem_addr_o, exp_pc);
        gnt_allow = 1'b1;
        run(12);

        // Jump with responses in flight on slow memory.
        p0      = n_pop;
        jump_c  = 1'b1;
        jaddr_c = 32'h0000_0100;
        step();
        jump_c = 1'b0;
        run(20);
        #3;
        chk("post_jump_progress", {31'b0, n_pop > p0}, 32'd1);

        // Jump coincident with rvalid and hold on zero-wait memory; target wraps.
        lat = 1;
        run(8);
        hold_c  = 1'b1;
        jump_c  = 1'b1;
        jaddr_c = 32'hFFFF_FFFC;
        step();
        #2;
        first_cyc = -1;
        hold_c    = 1'b0;
        jump_c    = 1'b0;
        step();
        chk("jump_req_t1", {31'b0, imem_req_o}, 32'd1);
        chk("jump_addr_t1", imem_addr_o, 32'hFFFF_FFFC);
        run(10);
        #3;
        chk("jump_first_valid", first_cyc, jump_cyc + 3);

        // Asynchronous reset with the queue occupied.
        lat    = 3;
        hold_c = 1'b1;
        run(6);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        pend.delete();
        exp_q.delete();
        hold_c        = 1'b0;
        hold_i        = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        lat           = 1;
        repeat (2) @(negedge clk);
        release_reset();
        run(8);
        #3;
        chk("restart_first_valid", first_cyc, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
